icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter NFRAMES, default 16, meaning number of direct-mapped one-word frames (power of two, 2..64).
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imemREN  input  1  datapath instruction fetch request.
REQ-005 SHALL have port imemaddr  input  32  datapath fetch byte address (word-aligned).
REQ-006 SHALL have port ihit  output  1  requested word valid this cycle.
REQ-007 SHALL have port imemload  output  32  fetched instruction.
REQ-008 SHALL have port iREN  output  1  memory-side read request.
REQ-009 SHALL have port iaddr  output  32  memory-side read address.
REQ-010 SHALL have port iwait  input  1  memory busy; iload valid when iwait=0 with iREN=1.
REQ-011 SHALL have port iload  input  32  memory read data.
REQ-012 SHALL have ports hit_count and miss_count  output  32 each  fetch statistics (see Configuration).

Function
REQ-013 Address split SHALL be: [1:0] ignored, [IDX+1:2] index, [31:IDX+2] tag, where IDX = log2(NFRAMES).
REQ-014 Each frame SHALL hold valid bit, tag, 32-bit data.
REQ-015 FSM SHALL have states IDLE and FILL.
REQ-016 In IDLE, ihit SHALL be 1 combinationally (zero-cycle latency) iff imemREN=1, indexed frame valid, and tag matches.
REQ-017 imemload SHALL equal indexed frame data when ihit=1, else 32'h0.
REQ-018 In IDLE, a miss (imemREN=1, no hit) SHALL latch imemaddr into miss_addr and move to FILL on the next edge.
REQ-019 In FILL, iREN SHALL be 1 and iaddr SHALL equal miss_addr; ihit SHALL be 0.
REQ-020 In FILL, on an edge with iwait=0, the frame at miss_addr index SHALL be written (valid=1, tag, data=iload) and the FSM SHALL return to IDLE.
REQ-021 Miss penalty SHALL be one cycle plus memory latency; the refetched word hits in the first IDLE cycle after fill.
REQ-022 In IDLE, iREN SHALL be 0 and iaddr SHALL be 32'h0.
REQ-023 A fill SHALL complete even if imemREN drops or imemaddr changes during FILL; no abort.
REQ-024 A fill to an occupied index SHALL overwrite it (conflict eviction), no write-back.

Reset
REQ-025 On RST=1, asynchronously: state=IDLE, all valid bits=0, miss_addr=0, counters=0; hence ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-026 RST asserted during FILL SHALL drop iREN immediately and discard the in-flight fill.
REQ-027 Tag and data arrays need not be reset.

Configuration
REQ-028 Macro ICACHE_STATS_EN SHALL control statistics.
REQ-029 With ICACHE_STATS_EN defined, hit_count SHALL increment on each edge with ihit=1, and miss_count on each IDLE->FILL transition; both saturate at 32'hFFFFFFFF.
REQ-030 Without ICACHE_STATS_EN, hit_count and miss_count SHALL be constant 0 and no counter registers SHALL be synthesized.

Verification
REQ-031 Reset, imemREN=1, imemaddr=0x00000000 -> ihit=0, next cycle iREN=1, iaddr=0x0.
REQ-032 Cold miss at 0x00000040, iwait=1 for 3 cycles then 0 with iload=0x8C220004 -> frame written; next cycle ihit=1, imemload=0x8C220004; iREN=0.
REQ-033 After REQ-032, fetch 0x00000080 (same index, NFRAMES=16, different tag) -> miss, fill, then fetch 0x00000040 misses again.
REQ-034 During FILL of 0x00000010 change imemaddr to 0x00000100 and drop imemREN -> iaddr stays 0x10 until iwait=0; frame 4 holds fetched word.
REQ-035 Assert RST while in FILL with iwait=1 -> iREN=0 same cycle; after release, previously hit address 0x00000040 misses.
REQ-036 With ICACHE_STATS_EN, 1 miss then 5 consecutive hits -> miss_count=1, hit_count=5; without the macro both read 0.

Source files
------------

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped instruction cache with one-word frames. A hit is
//            answered combinationally in the same cycle as the request. A miss
//            captures the fetch address and enters FILL. FILL holds a memory
//            read until iwait drops, then writes the frame and returns to IDLE.
// Ports    : CLK, RST            - clock and asynchronous active-high reset
//            imemREN, imemaddr   - datapath fetch request and byte address
//            ihit, imemload      - hit strobe and fetched word (0 on no hit)
//            iREN, iaddr         - memory-side read request and address
//            iwait, iload        - memory busy flag and read data
//            hit_count,
//            miss_count          - fetch statistics (0 unless enabled)
// Config   : define ICACHE_STATS_EN to build the saturating hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module icache #(
  parameter int NFRAMES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX  = $clog2(NFRAMES);
  localparam int TAGW = 30 - IDX;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         miss_addr_q, miss_addr_d;
  logic [NFRAMES-1:0]  valid_q, valid_d;

  // Tag and data storage carry no reset; the valid bits alone gate their use.
  logic [TAGW-1:0]     tag_q  [NFRAMES];
  logic [31:0]         data_q [NFRAMES];

  logic [IDX-1:0]      req_idx, fill_idx;
  logic [TAGW-1:0]     req_tag, fill_tag;
  logic                hit;
  logic                fill_done;

  assign req_idx  = imemaddr[IDX+1:2];
  assign req_tag  = imemaddr[31:IDX+2];
  assign fill_idx = miss_addr_q[IDX+1:2];
  assign fill_tag = miss_addr_q[31:IDX+2];

  // Lookups are only honoured in IDLE so a FILL never reports a hit.
  assign hit = (state_q == IDLE) && imemREN && valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag);

  assign ihit     = hit;
  assign imemload = hit ? data_q[req_idx] : 32'h0;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    iREN        = 1'b0;
    iaddr       = 32'h0;
    fill_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit) begin
          miss_addr_d = imemaddr;
          state_d     = FILL;
        end
      end
      FILL: begin
        // The fill runs to completion from the latched address; datapath
        // request changes during FILL are ignored.
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        if (!iwait) begin
          fill_done         = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= 32'h0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      valid_q     <= valid_d;
    end
  end

  // fill_done is derived from state_q, which reset forces to IDLE, so an
  // in-flight fill is dropped while RST is asserted.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      if (hit && (hit_cnt_q != 32'hFFFF_FFFF))
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == IDLE) && (state_d == FILL) && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache
// Purpose  : Self-checking bench for icache. A reference model keeps, for each
//            frame, whether it is valid and which word address it holds, plus
//            the expected hit/miss totals. It is driven with directed scenarios
//            and a randomized fetch stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache;

  localparam int NF = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int tests = 0;
  int fails = 0;

  // Reference model: frame contents as word addresses, and statistics.
  bit          m_valid [NF];
  logic [29:0] m_word  [NF];
  logic [31:0] m_data  [NF];
  int unsigned m_hits;
  int unsigned m_misses;

  icache #(.NFRAMES(NF)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic int frame_of(input logic [31:0] a);
    return int'((a >> 2) % NF);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Assert reset off-edge, hold across one rising edge, release off-edge.
  task automatic do_reset();
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    RST      = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    #1;
  endtask

  // One fetch from IDLE. On a miss, the fill is served after 'waits' busy
  // cycles with 'data'. If 'disturb' is set the datapath withdraws its request
  // and moves its address during the fill. Returns at edge+1 in IDLE.
  task automatic fetch(input logic [31:0] a, input int waits,
                       input logic [31:0] data, input bit disturb);
    int  f;
    bit  exp_hit;
    logic [31:0] exp_load;
    f        = frame_of(a);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    #1;
    exp_hit  = m_valid[f] && (m_word[f] == a[31:2]);
    exp_load = exp_hit ? m_data[f] : 32'h0;
    tests++;
    if (ihit !== exp_hit) begin
      fails++;
      $display("FAIL ihit addr=%h got=%b exp=%b", a, ihit, exp_hit);
    end
    tests++;
    if (imemload !== exp_load) begin
      fails++;
      $display("FAIL imemload addr=%h got=%h exp=%h", a, imemload, exp_load);
    end
    tests++;
    if (iREN !== 1'b0 || iaddr !== 32'h0) begin
      fails++;
      $display("FAIL idle_mem addr=%h got iREN=%b iaddr=%h exp 0/0", a, iREN, iaddr);
    end
    @(posedge CLK); #1;
    if (exp_hit) begin
      m_hits++;
      return;
    end
    m_misses++;
    for (int w = 0; w <= waits; w++) begin
      if (disturb) begin
        imemREN  = 1'b0;
        imemaddr = 32'h0000_0100;
      end
      iwait = (w < waits);
      iload = (w < waits) ? $urandom : data;
      #1;
      tests++;
      if (iREN !== 1'b1 || iaddr !== a || ihit !== 1'b0) begin
        fails++;
        $display("FAIL fill addr=%h got iREN=%b iaddr=%h ihit=%b exp 1/%h/0",
                 a, iREN, iaddr, ihit, a);
      end
      @(posedge CLK); #1;
    end
    m_valid[f] = 1'b1;
    m_word[f]  = a[31:2];
    m_data[f]  = data;
    iwait      = 1'b1;
    imemREN    = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int unsigned eh,
                              input int unsigned em);
    logic [31:0] xh, xm;
`ifdef ICACHE_STATS_EN
    xh = eh;
    xm = em;
`else
    xh = 32'h0;
    xm = 32'h0;
`endif
    tests++;
    if (hit_count !== xh) begin
      fails++;
      $display("FAIL %s hit_count got=%0d exp=%0d", tag, hit_count, xh);
    end
    tests++;
    if (miss_count !== xm) begin
      fails++;
      $display("FAIL %s miss_count got=%0d exp=%0d", tag, miss_count, xm);
    end
  endtask

  task automatic test_reset();
    RST      = 1'b1;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    #1;
    tests++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs got ihit=%b load=%h iREN=%b iaddr=%h exp all 0",
               ihit, imemload, iREN, iaddr);
    end
    check_counts("reset", 0, 0);
    do_reset();
  endtask

  // Cold miss at 0x0 then the 0x40 fill with three busy cycles.
  task automatic test_cold_miss();
    do_reset();
    fetch(32'h0000_0000, 0, mem_word(32'h0), 1'b0);
    fetch(32'h0000_0040, 3, 32'h8C22_0004, 1'b0);
    fetch(32'h0000_0040, 0, 32'h0, 1'b0);
    tests++;
    if (imemload !== 32'h8C22_0004 && ihit !== 1'b1) begin
      fails++;
      $display("FAIL refetch_0x40 got load=%h exp=8c220004", imemload);
    end
  endtask

  task automatic test_conflict();
    fetch(32'h0000_0080, 1, mem_word(32'h80), 1'b0);
    fetch(32'h0000_0080, 0, 32'h0, 1'b0);
    fetch(32'h0000_0040, 2, 32'h8C22_0004, 1'b0);
  endtask

  task automatic test_fill_disturb();
    fetch(32'h0000_0010, 2, 32'hDEAD_0010, 1'b1);
    imemREN  = 1'b0;
    imemaddr = 32'h0000_0010;
    #1;
    tests++;
    if (ihit !== 1'b0 || imemload !== 32'h0) begin
      fails++;
      $display("FAIL no_req got ihit=%b load=%h exp 0/0", ihit, imemload);
    end
    @(posedge CLK); #1;
    fetch(32'h0000_0010, 0, 32'h0, 1'b0);
    fetch(32'h0000_0100, 1, mem_word(32'h100), 1'b0);
  endtask

  task automatic test_reset_in_fill();
    fetch(32'h0000_0040, 0, 32'h8C22_0004, 1'b0);
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0200;
    iwait    = 1'b1;
    @(posedge CLK); #1;
    tests++;
    if (iREN !== 1'b1) begin
      fails++;
      $display("FAIL enter_fill got iREN=%b exp=1", iREN);
    end
    RST = 1'b1;
    #1;
    tests++;
    if (iREN !== 1'b0 || iaddr !== 32'h0) begin
      fails++;
      $display("FAIL reset_in_fill got iREN=%b iaddr=%h exp 0/0", iREN, iaddr);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    imemREN = 1'b0;
    #1;
    fetch(32'h0000_0040, 1, 32'h8C22_0004, 1'b0);
  endtask

  task automatic test_stats();
    do_reset();
    fetch(32'h0000_0020, 1, mem_word(32'h20), 1'b0);
    for (int k = 0; k < 5; k++) fetch(32'h0000_0020, 0, 32'h0, 1'b0);
    imemREN = 1'b0;
    #1;
    check_counts("stats", 5, 1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        imemREN  = 1'b0;
        imemaddr = $urandom;
        #1;
        tests++;
        if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0) begin
          fails++;
          $display("FAIL rand_idle got ihit=%b load=%h iREN=%b exp 0", ihit, imemload, iREN);
        end
        @(posedge CLK); #1;
      end else begin
        a = {20'h0, 4'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 2'b00};
        fetch(a, int'($urandom_range(0, 3)), mem_word(a), bit'($urandom_range(0, 1)));
      end
    end
    imemREN = 1'b0;
    #1;
    check_counts("random", m_hits, m_misses);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cold_miss();
    test_conflict();
    test_fill_disturb();
    test_reset_in_fill();
    test_stats();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
